// File: rtl/sdr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sdr_arbiter_if
// Description : SDRAM-side bus of the multi-channel SDRAM arbiter. The
//               arbiter drives address/data/direction and a toggle request;
//               the controller answers with a toggle acknowledge and read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdr_arbiter_if;
    logic [26:0] sdr_addr;
    logic [63:0] sdr_data;
    logic [7:0]  sdr_be;
    logic        sdr_rw;
    logic        sdr_req;
    logic        sdr_ack;
    logic [63:0] sdr_q;

    modport master (
        output sdr_addr, sdr_data, sdr_be, sdr_rw, sdr_req,
        input  sdr_ack, sdr_q
    );

    modport slave (
        input  sdr_addr, sdr_data, sdr_be, sdr_rw, sdr_req,
        output sdr_ack, sdr_q
    );
endinterface
`default_nettype wire

// File: rtl/sdr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdr_arbiter
// Description : Fixed-priority arbiter with starvation promotion that funnels
//               NUM_CH toggle-handshake requesters onto one SDRAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module sdr_arbiter #(
    parameter int NUM_CH       = 5,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arb_enable,
    input  logic [NUM_CH-1:0]    ch_req,
    output logic [NUM_CH-1:0]    ch_ack,
    input  logic [NUM_CH*27-1:0] ch_addr,
    input  logic [NUM_CH-1:0]    ch_rw,
    input  logic [NUM_CH*16-1:0] ch_data,
    input  logic [NUM_CH*2-1:0]  ch_be,
    output logic [NUM_CH*64-1:0] ch_q,
    output logic                 busy,
    output logic [2:0]           grant_ch,
    sdr_arbiter_if.master        sdr
);

    localparam logic [0:0] c_idle   = 1'b0;
    localparam logic [0:0] c_active = 1'b1;

    localparam logic [4:0] c_starve_limit = 5'(STARVE_LIMIT);
    localparam logic [4:0] c_wait_max     = 5'd31;

    logic [0:0]           r_state;
    logic [NUM_CH-1:0]    r_ack;
    logic [NUM_CH*64-1:0] r_q;
    logic [26:0]          r_addr;
    logic [63:0]          r_data;
    logic [7:0]           r_be;
    logic                 r_rw;
    logic                 r_req;
    logic                 r_busy;
    logic [2:0]           r_grant;
    logic [4:0]           r_wait [NUM_CH];

    logic [NUM_CH-1:0]    w_pend;
    logic [NUM_CH-1:0]    w_starve;
    logic [NUM_CH-1:0]    w_hold;
    logic [2:0]           w_win_pri;
    logic [2:0]           w_win_stv;
    logic [2:0]           w_win;
    logic                 w_grant;
    logic                 w_done;

    // Per-channel pending, starvation and "counter held at zero" flags
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign w_pend[g]   = ch_req[g] ^ r_ack[g];
        assign w_starve[g] = w_pend[g] && (r_wait[g] >= c_starve_limit);
        // A channel being granted now, or already in flight, does not age
        assign w_hold[g]   = (w_grant && (w_win == 3'(g))) ||
                             (r_busy && (r_grant == 3'(g)));
    end

    // Lowest-index pending and lowest-index starving channel
    always_comb begin
        w_win_pri = '0;
        w_win_stv = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_win_pri = 3'(i);
            end
            if (w_starve[i]) begin
                w_win_stv = 3'(i);
            end
        end
    end

    assign w_win   = (|w_starve) ? w_win_stv : w_win_pri;
    assign w_grant = (r_state == c_idle) && arb_enable && (|w_pend);
    assign w_done  = (r_state == c_active) && (sdr.sdr_ack == r_req);

    // Grant / completion state machine and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_idle;
            r_ack   <= '0;
            r_q     <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_be    <= '0;
            r_rw    <= 1'b1;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_grant <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_grant) begin
                        r_state <= c_active;
                        r_grant <= w_win;
                        r_addr  <= ch_addr[27*w_win +: 27];
                        r_rw    <= ch_rw[w_win];
                        // Reads leave the last write data/enables on the bus
                        if (!ch_rw[w_win]) begin
                            r_data <= {48'd0, ch_data[16*w_win +: 16]};
                            r_be   <= {6'd0, ch_be[2*w_win +: 2]};
                        end
                        r_busy  <= 1'b1;
                        r_req   <= ~r_req;
                    end
                end
                c_active: begin
                    if (w_done) begin
                        r_ack[r_grant] <= ch_req[r_grant];
                        if (r_rw) begin
                            r_q[64*r_grant +: 64] <= sdr.sdr_q;
                        end
                        r_busy  <= 1'b0;
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // Wait counters: age while pending and not served, saturate at 31
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_pend[i] || w_hold[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != c_wait_max) begin
                    r_wait[i] <= r_wait[i] + 5'd1;
                end
            end
        end
    end

    assign ch_ack       = r_ack;
    assign ch_q         = r_q;
    assign busy         = r_busy;
    assign grant_ch     = r_grant;
    assign sdr.sdr_addr = r_addr;
    assign sdr.sdr_data = r_data;
    assign sdr.sdr_be   = r_be;
    assign sdr.sdr_rw   = r_rw;
    assign sdr.sdr_req  = r_req;

endmodule
`default_nettype wire

// File: tb/tb_sdr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdr_arbiter
// Description : Scoreboard bench for sdr_arbiter. Stimulus pushes expected
//               grants/completions; a monitor pops them whenever sdr_req or
//               ch_ack toggles. A small SDRAM responder answers requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdr_arbiter;

    localparam int NUM_CH = 5;

    typedef struct {
        int          ch;
        logic [26:0] addr;
        logic        rw;
        logic [63:0] data;
        logic [7:0]  be;
        int          gap;
    } grant_t;

    typedef struct {
        int          ch;
        logic        rd;
        logic [63:0] q;
    } cmp_t;

    logic                 clk;
    logic                 reset_n;
    logic                 arb_enable;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH-1:0]    ch_ack;
    logic [NUM_CH*27-1:0] ch_addr;
    logic [NUM_CH-1:0]    ch_rw;
    logic [NUM_CH*16-1:0] ch_data;
    logic [NUM_CH*2-1:0]  ch_be;
    logic [NUM_CH*64-1:0] ch_q;
    logic                 busy;
    logic [2:0]           grant_ch;

    sdr_arbiter_if sdr_bus ();

    sdr_arbiter #(.NUM_CH(NUM_CH), .STARVE_LIMIT(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .arb_enable (arb_enable),
        .ch_req     (ch_req),
        .ch_ack     (ch_ack),
        .ch_addr    (ch_addr),
        .ch_rw      (ch_rw),
        .ch_data    (ch_data),
        .ch_be      (ch_be),
        .ch_q       (ch_q),
        .busy       (busy),
        .grant_ch   (grant_ch),
        .sdr        (sdr_bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_cmp = 0;
    grant_t      gq[$];
    cmp_t        cq[$];
    logic [63:0] mq [NUM_CH];
    logic [63:0] exp_data = '0;
    logic [7:0]  exp_be = '0;
    int          mem_lat = 1;
    logic        mem_hold = 1'b0;
    int          glitch_n = 0;
    int          glitch_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] memval(input logic [26:0] a);
        if (a == 27'h12345) return 64'hDEADBEEF_01234567;
        return {5'd0, a, 5'd0, ~a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [26:0] a, input logic rw,
                          input logic [15:0] d, input logic [1:0] be);
        ch_addr[ch*27 +: 27] = a;
        ch_rw[ch]            = rw;
        ch_data[ch*16 +: 16] = d;
        ch_be[ch*2 +: 2]     = be;
    endtask

    // Expected grant and completion for the channel's current request
    task automatic exp_txn(input int ch, input int gap);
        grant_t g;
        cmp_t   c;
        g.ch   = ch;
        g.addr = ch_addr[ch*27 +: 27];
        g.rw   = ch_rw[ch];
        if (!ch_rw[ch]) begin
            exp_data = {48'd0, ch_data[ch*16 +: 16]};
            exp_be   = {6'd0, ch_be[ch*2 +: 2]};
        end
        g.data = exp_data;
        g.be   = exp_be;
        g.gap  = gap;
        gq.push_back(g);
        c.ch = ch;
        c.rd = ch_rw[ch];
        c.q  = memval(g.addr);
        cq.push_back(c);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((gq.size() != 0 || cq.size() != 0 || busy) && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL drain_timeout: %0d grants and %0d completions still outstanding after %0d cycles",
                     gq.size(), cq.size(), bound);
        end
    endtask

    task automatic chk_reset();
        chk("rst_sdr_req", sdr_bus.sdr_req, 0);
        chk("rst_ch_ack", ch_ack, 0);
        chk("rst_ch_q_zero", |ch_q, 0);
        chk("rst_sdr_addr", sdr_bus.sdr_addr, 0);
        chk("rst_sdr_data", sdr_bus.sdr_data, 0);
        chk("rst_sdr_be", sdr_bus.sdr_be, 0);
        chk("rst_sdr_rw", sdr_bus.sdr_rw, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grant_ch", grant_ch, 0);
    endtask

    // SDRAM responder: toggles sdr_ack mem_lat falling edges after a request
    initial begin
        int  rcnt = 0;
        bit  restore = 0;
        sdr_bus.sdr_ack = 1'b0;
        sdr_bus.sdr_q   = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sdr_bus.sdr_ack = 1'b0;
                rcnt    = 0;
                restore = 0;
            end else if (restore) begin
                sdr_bus.sdr_ack = ~sdr_bus.sdr_ack;
                restore = 0;
            end else if (glitch_done < glitch_n) begin
                sdr_bus.sdr_ack = ~sdr_bus.sdr_ack;
                restore = 1;
                glitch_done++;
            end else if (!mem_hold && (sdr_bus.sdr_req != sdr_bus.sdr_ack)) begin
                rcnt++;
                if (rcnt >= mem_lat) begin
                    sdr_bus.sdr_q   = memval(sdr_bus.sdr_addr);
                    sdr_bus.sdr_ack = sdr_bus.sdr_req;
                    rcnt = 0;
                end
            end
        end
    end

    // Monitor: each sdr_req toggle is a grant, each ch_ack change a completion
    initial begin
        logic              prev_req = 1'b0;
        logic [NUM_CH-1:0] prev_ack = '0;
        logic [NUM_CH-1:0] diff;
        grant_t            g;
        cmp_t              c;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_req = sdr_bus.sdr_req;
                prev_ack = ch_ack;
                for (int i = 0; i < NUM_CH; i++) mq[i] = '0;
            end else begin
                if (sdr_bus.sdr_req !== prev_req) begin
                    prev_req = sdr_bus.sdr_req;
                    if (gq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: grant_ch=%0d, no grant expected", grant_ch);
                    end else begin
                        g = gq.pop_front();
                        chk("grant_ch", grant_ch, g.ch);
                        chk("grant_addr", sdr_bus.sdr_addr, g.addr);
                        chk("grant_rw", sdr_bus.sdr_rw, g.rw);
                        chk("grant_data", sdr_bus.sdr_data, g.data);
                        chk("grant_be", sdr_bus.sdr_be, g.be);
                        chk("grant_busy", busy, 1);
                        if (g.gap >= 0) chk("grant_gap", 64'(cyc - last_cmp), 64'(g.gap));
                    end
                end
                if (ch_ack !== prev_ack) begin
                    diff     = ch_ack ^ prev_ack;
                    prev_ack = ch_ack;
                    last_cmp = cyc;
                    if (cq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: ch_ack=0x%0h, no completion expected", ch_ack);
                    end else begin
                        c = cq.pop_front();
                        chk("cmp_ack_bit", diff, 64'(1) << c.ch);
                        if (c.rd) mq[c.ch] = c.q;
                        for (int i = 0; i < NUM_CH; i++) chk("cmp_ch_q", ch_q[i*64 +: 64], mq[i]);
                        chk("cmp_busy", busy, 0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n0;
        bit  seen4;
        reset_n    = 1'b0;
        arb_enable = 1'b1;
        ch_req     = '0;
        ch_addr    = '0;
        ch_rw      = '1;
        ch_data    = '0;
        ch_be      = '0;

        // Reset values, asserted before any clock edge
        #12;
        chk_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // Single read on channel 3
        mem_lat = 1;
        set_ch(3, 27'h12345, 1'b1, 16'h0, 2'b00);
        exp_txn(3, -1);
        ch_req[3] = ~ch_req[3];
        tick();
        chk("rd_next_req", sdr_bus.sdr_req, 1);
        chk("rd_next_busy", busy, 1);
        wait_idle(20);
        chk("rd_ack3", ch_ack[3], 1);
        chk("rd_q3", ch_q[3*64 +: 64], 64'hDEADBEEF_01234567);

        // sdr_ack toggling while idle must not complete anything
        glitch_n++;
        repeat (4) tick();
        chk("idle_ack_ignored_busy", busy, 0);
        chk("idle_ack_ignored_ack", ch_ack, 5'b01000);

        // Simultaneous requests: ch1 first, ch4 one idle cycle later
        mem_lat = 3;
        set_ch(1, 27'h0000111, 1'b1, 16'h0, 2'b00);
        set_ch(4, 27'h7FFFFFF, 1'b1, 16'h0, 2'b00);
        exp_txn(1, -1);
        exp_txn(4, 1);
        ch_req[1] = ~ch_req[1];
        ch_req[4] = ~ch_req[4];
        wait_idle(40);

        // Write on ch4; inputs changed after grant must not leak through
        set_ch(4, 27'h0ABCDEF, 1'b0, 16'hA55A, 2'b10);
        exp_txn(4, -1);
        ch_req[4] = ~ch_req[4];
        tick();
        set_ch(4, 27'h0000F0F, 1'b1, 16'h1234, 2'b01);
        tick();
        chk("wr_hold_addr", sdr_bus.sdr_addr, 27'h0ABCDEF);
        chk("wr_hold_data", sdr_bus.sdr_data, 64'h000000000000A55A);
        chk("wr_hold_be", sdr_bus.sdr_be, 8'h02);
        chk("wr_hold_rw", sdr_bus.sdr_rw, 0);
        wait_idle(20);
        // A read keeps the last write data/enables on the bus
        set_ch(2, 27'h0000200, 1'b1, 16'hFFFF, 2'b11);
        exp_txn(2, -1);
        ch_req[2] = ~ch_req[2];
        wait_idle(20);

        // arb_enable dropped while active: finish, then block ch2 until re-enabled
        mem_hold = 1'b1;
        set_ch(1, 27'h0000055, 1'b1, 16'h0, 2'b00);
        exp_txn(1, -1);
        ch_req[1] = ~ch_req[1];
        tick();
        arb_enable = 1'b0;
        set_ch(2, 27'h0000066, 1'b1, 16'h0, 2'b00);
        ch_req[2] = ~ch_req[2];
        repeat (3) tick();
        mem_hold = 1'b0;
        wait_idle(20);
        repeat (4) tick();
        chk("disabled_no_grant", busy, 0);
        exp_txn(2, -1);
        arb_enable = 1'b1;
        tick();
        chk("enable_grant_ch", grant_ch, 2);
        chk("enable_grant_busy", busy, 1);
        wait_idle(20);

        // Starvation: ch0 re-requests back-to-back, ch4 promoted after 16 waits
        mem_lat = 2;
        set_ch(0, 27'h0000010, 1'b1, 16'h0, 2'b00);
        set_ch(4, 27'h0000040, 1'b1, 16'h0, 2'b00);
        exp_txn(0, -1);
        for (int k = 0; k < 5; k++) exp_txn(0, 1);
        exp_txn(4, 1);
        exp_txn(0, 1);
        ch_req[0] = ~ch_req[0];
        ch_req[4] = ~ch_req[4];
        n0    = 1;
        seen4 = 0;
        for (int c = 0; c < 45; c++) begin
            tick();
            if (n0 < 7 && ch_ack[0] == ch_req[0]) begin
                ch_req[0] = ~ch_req[0];
                n0++;
            end
            if (!seen4 && busy && grant_ch == 3'd4) begin
                seen4 = 1;
                chk("starve_grant_cycle", 64'(c), 64'd18);
                chk("starve_wait_cleared", dut.r_wait[4], 0);
            end
        end
        if (!seen4) begin
            checks++;
            errors++;
            $display("FAIL starve_grant: ch4 never granted, expected within 19 cycles");
        end
        wait_idle(30);

        // Reset mid-transaction: outputs clear at once, pending request re-granted
        reset_n = 1'b0;
        ch_req  = '0;
        gq.delete();
        cq.delete();
        exp_data = '0;
        exp_be   = '0;
        repeat (2) tick();
        reset_n  = 1'b1;
        mem_hold = 1'b1;
        set_ch(3, 27'h0000333, 1'b1, 16'h0, 2'b00);
        exp_txn(3, -1);
        ch_req[3] = ~ch_req[3];
        tick();
        tick();
        chk("pre_reset_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_reset();
        gq.delete();
        cq.delete();
        exp_txn(3, -1);
        mem_hold = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("regrant_ch", grant_ch, 3);
        chk("regrant_busy", busy, 1);
        chk("regrant_req", sdr_bus.sdr_req, 1);
        wait_idle(20);
        chk("regrant_ack3", ch_ack[3], 1);

        chk("queues_drained", 64'(gq.size() + cq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
